// File: rtl/mem_bus_sequencer.sv
// Shares one memory bus between the instruction-fetch and load/store ports.
// Data has fixed priority; one transaction at a time, held stable across stalls.
module mem_bus_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TCW            = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        bus_err,
    output logic        busy,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    typedef enum logic {GNT_FETCH, GNT_DATA} grant_t;

    state_t         state_q, state_d;
    grant_t         grant_q, grant_d;
    logic [TCW-1:0] cnt_q, cnt_d;

    logic [31:0] address_d, writedata_d, if_rdata_d, d_rdata_d;
    logic        read_d, write_d, if_done_d, d_done_d, bus_err_d, busy_d;
    logic [3:0]  byteenable_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= GNT_FETCH;
            cnt_q      <= '0;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            bus_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            address    <= address_d;
            read       <= read_d;
            write      <= write_d;
            writedata  <= writedata_d;
            byteenable <= byteenable_d;
            if_rdata   <= if_rdata_d;
            d_rdata    <= d_rdata_d;
            if_done    <= if_done_d;
            d_done     <= d_done_d;
            bus_err    <= bus_err_d;
            busy       <= busy_d;
        end
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        address_d    = address;
        read_d       = read;
        write_d      = write;
        writedata_d  = writedata;
        byteenable_d = byteenable;
        if_rdata_d   = if_rdata;
        d_rdata_d    = d_rdata;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        bus_err_d    = bus_err;

        case (state_q)
            IDLE: begin
                bus_err_d = 1'b0;
                if (d_req) begin
                    grant_d      = GNT_DATA;
                    state_d      = BUS;
                    cnt_d        = '0;
                    address_d    = {d_addr[31:2], 2'b00};
                    read_d       = ~d_we;
                    write_d      = d_we;
                    byteenable_d = d_be;
                    writedata_d  = d_wdata;
                end else if (if_req) begin
                    grant_d      = GNT_FETCH;
                    state_d      = BUS;
                    cnt_d        = '0;
                    address_d    = {if_addr[31:2], 2'b00};
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    byteenable_d = 4'b1111;
                    writedata_d  = '0;
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    if (read) begin
                        if (grant_q == GNT_DATA) d_rdata_d  = readdata;
                        else                     if_rdata_d = readdata;
                    end
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    byteenable_d = '0;
                    bus_err_d    = 1'b0;
                    state_d      = RESP;
                    if (grant_q == GNT_DATA) d_done_d  = 1'b1;
                    else                     if_done_d = 1'b1;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    // Slave never answered: abandon the cycle and flag it.
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = RESP;
                    if (grant_q == GNT_DATA) begin
                        d_rdata_d = '0;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = '0;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + TCW'(1);
                end
            end
            RESP: begin
                state_d   = IDLE;
                cnt_d     = '0;
                bus_err_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench: transactions are planned on a cycle timeline, and a compare
// process checks the DUT against that timeline on every cycle.
module tb_mem_bus_sequencer;

    localparam int NC = 72;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, waitrequest;
    logic [31:0] if_addr, d_addr, d_wdata, readdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, address, writedata;
    logic        if_done, d_done, bus_err, busy, read, write;
    logic [3:0]  byteenable;

    mem_bus_sequencer #(.TIMEOUT_CYCLES(TO), .TCW(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_done(d_done), .bus_err(bus_err), .busy(busy),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    // Stimulus schedule, indexed by cycle.
    logic        s_rst [NC], s_if_req [NC], s_d_req [NC], s_d_we [NC], s_wait [NC];
    logic [31:0] s_if_addr [NC], s_d_addr [NC], s_d_wdata [NC], s_rd [NC];
    logic [3:0]  s_d_be [NC];
    // Expected outputs, indexed by cycle.
    logic        x_read [NC], x_write [NC], x_busy [NC], x_if_done [NC], x_d_done [NC], x_err [NC];
    logic [31:0] x_addr [NC], x_wd [NC];
    logic [3:0]  x_be [NC];
    logic        ev_if [NC], ev_d [NC];
    logic [31:0] ev_if_v [NC], ev_d_v [NC];

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    logic [31:0] m_if_rdata = 32'h0;
    logic [31:0] m_d_rdata  = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    // Lay one transaction onto the timeline: request at cycle k, nwait stall
    // cycles, strobes from k+1, done at k+2+nwait (or k+1+TO on timeout).
    // cut>0 means reset is applied in that cycle and the transaction dies.
    task automatic plan(input int k, input int req_from, input bit is_d, input bit we,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input int nwait, input logic [31:0] rd, input int cut);
        bit to;
        int s, dn, last;
        to   = (nwait >= TO);
        s    = to ? TO : nwait + 1;
        dn   = k + 1 + s;
        last = (cut > 0) ? cut : dn;
        for (int c = req_from; c < last; c++) begin
            if (is_d) begin
                s_d_req[c] = 1'b1; s_d_we[c] = we; s_d_addr[c] = a;
                s_d_wdata[c] = wd; s_d_be[c] = be;
            end else begin
                s_if_req[c] = 1'b1; s_if_addr[c] = a;
            end
        end
        for (int c = k + 1; c <= k + s && (cut == 0 || c < cut); c++) begin
            x_read[c]  = !(is_d && we);
            x_write[c] = is_d && we;
            x_addr[c]  = {a[31:2], 2'b00};
            x_wd[c]    = is_d ? wd : 32'h0;
            x_be[c]    = is_d ? be : 4'hF;
            x_busy[c]  = 1'b1;
            s_wait[c]  = to || (c != k + s);
            s_rd[c]    = (c == k + s) ? rd : ~rd;
        end
        if (cut == 0) begin
            x_busy[dn] = 1'b1;
            x_err[dn]  = to;
            if (is_d) x_d_done[dn] = 1'b1; else x_if_done[dn] = 1'b1;
            if (to || !(is_d && we)) begin
                if (is_d) begin ev_d[dn] = 1'b1;  ev_d_v[dn]  = to ? 32'h0 : rd; end
                else      begin ev_if[dn] = 1'b1; ev_if_v[dn] = to ? 32'h0 : rd; end
            end
        end
    endtask

    task automatic drive(input int c);
        reset       = s_rst[c];
        if_req      = s_if_req[c];
        if_addr     = s_if_addr[c];
        d_req       = s_d_req[c];
        d_we        = s_d_we[c];
        d_addr      = s_d_addr[c];
        d_wdata     = s_d_wdata[c];
        d_be        = s_d_be[c];
        waitrequest = s_wait[c];
        readdata    = s_rd[c];
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            s_rst[c] = 1'b0; s_if_req[c] = 1'b0; s_d_req[c] = 1'b0; s_d_we[c] = 1'b0;
            s_wait[c] = 1'b0; s_if_addr[c] = 32'h0; s_d_addr[c] = 32'h0;
            s_d_wdata[c] = 32'h0; s_rd[c] = 32'h0; s_d_be[c] = 4'h0;
            x_read[c] = 1'b0; x_write[c] = 1'b0; x_busy[c] = 1'b0; x_if_done[c] = 1'b0;
            x_d_done[c] = 1'b0; x_err[c] = 1'b0; x_addr[c] = 32'h0; x_wd[c] = 32'h0;
            x_be[c] = 4'h0; ev_if[c] = 1'b0; ev_d[c] = 1'b0; ev_if_v[c] = 32'h0; ev_d_v[c] = 32'h0;
        end
        for (int c = 0; c < 3; c++) s_rst[c] = 1'b1;
        s_wait[3] = 1'b1; s_wait[4] = 1'b1;
        plan(5,  5,  1'b0, 1'b0, 32'hBFC00003, 32'h0, 4'h0, 0, 32'h8C220004, 0);
        plan(10, 10, 1'b1, 1'b1, 32'h00001004, 32'hDEADBEEF, 4'b0011, 3, 32'h0, 0);
        plan(20, 20, 1'b1, 1'b0, 32'h00002000, 32'h0, 4'b1111, 0, 32'h12345678, 0);
        plan(23, 20, 1'b0, 1'b0, 32'h00400010, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0);
        plan(30, 30, 1'b1, 1'b0, 32'h00000300, 32'h0, 4'b1111, 20, 32'h77777777, 0);
        plan(45, 45, 1'b1, 1'b1, 32'h00002007, 32'hA5A50000, 4'b1100, 0, 32'h0, 0);
        plan(48, 48, 1'b0, 1'b0, 32'h00000010, 32'h0, 4'h0, 0, 32'h11112222, 0);
        plan(55, 55, 1'b0, 1'b0, 32'h00000040, 32'h0, 4'h0, 10, 32'h99999999, 58);
        s_rst[58] = 1'b1;
        plan(62, 62, 1'b0, 1'b0, 32'h00000044, 32'h0, 4'h0, 1, 32'h55AA55AA, 0);

        drive(0);
        for (int c = 1; c < NC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            drive(c);
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Compare every cycle, mid-cycle, against the planned timeline.
    always @(negedge clk) begin
        if (s_rst[cyc]) begin
            m_if_rdata = 32'h0;
            m_d_rdata  = 32'h0;
        end
        if (ev_if[cyc]) m_if_rdata = ev_if_v[cyc];
        if (ev_d[cyc])  m_d_rdata  = ev_d_v[cyc];

        chk("read",     32'(read),    32'(x_read[cyc]));
        chk("write",    32'(write),   32'(x_write[cyc]));
        chk("busy",     32'(busy),    32'(x_busy[cyc]));
        chk("if_done",  32'(if_done), 32'(x_if_done[cyc]));
        chk("d_done",   32'(d_done),  32'(x_d_done[cyc]));
        chk("bus_err",  32'(bus_err), 32'(x_err[cyc]));
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata",  d_rdata,  m_d_rdata);
        chk("rw_excl",  32'(read & write), 32'h0);
        if (x_read[cyc] || x_write[cyc]) begin
            chk("address",    address,          x_addr[cyc]);
            chk("writedata",  writedata,        x_wd[cyc]);
            chk("byteenable", 32'(byteenable),  32'(x_be[cyc]));
        end

        case (cyc)
            2:  begin chk("pin_rst_addr", address, 32'h0); chk("pin_rst_be", 32'(byteenable), 32'h0); end
            6:  chk("pin_fetch_addr", address, 32'hBFC00000);
            7:  chk("pin_fetch_rdata", if_rdata, 32'h8C220004);
            12: begin chk("pin_st_wd", writedata, 32'hDEADBEEF); chk("pin_st_be", 32'(byteenable), 32'h3); end
            15: chk("pin_st_done", 32'(d_done), 32'h1);
            22: chk("pin_ld_rdata", d_rdata, 32'h12345678);
            25: chk("pin_ct_if_done", 32'(if_done), 32'h1);
            38: chk("pin_to_read", 32'(read), 32'h1);
            39: begin chk("pin_to_err", 32'(bus_err), 32'h1); chk("pin_to_rdata", d_rdata, 32'h0); end
            40: chk("pin_to_busy", 32'(busy), 32'h0);
            46: chk("pin_st2_addr", address, 32'h00002004);
            58: begin chk("pin_rst_read", 32'(read), 32'h0); chk("pin_rst_busy", 32'(busy), 32'h0); end
            65: chk("pin_post_rst", if_rdata, 32'h55AA55AA);
            default: ;
        endcase
    end

endmodule
